kronos_instr_prefetch: RTL and testbench

Sequential instruction prefetch buffer between the instruction memory and the `kronos_core` fetch port (`instr_addr/instr_req/instr_data/instr_ack`). It speculatively fetches sequential words into a small FIFO and answers core fetches from the buffer head. It flushes and refetches when the core requests a non-sequential address (branch, jump or trap). It allows at most one outstanding memory request and drops responses from stale, already-issued requests.

---
 rtl/kronos_instr_prefetch.sv | 112 +++++++++++
 tb/tb_kronos_instr_prefetch.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kronos_instr_prefetch.sv
// Sequential instruction prefetch buffer between instruction memory and the kronos_core fetch port.
// Fills a small FIFO with sequential words; a non-sequential fetch flushes it and refetches.
module kronos_instr_prefetch #(
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] BOOT_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic [31:0] instr_addr,
    input  logic        instr_req,
    output logic [31:0] instr_data,
    output logic        instr_ack,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        redirect
);
    localparam int unsigned   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   CW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DROP
    } state_t;

    state_t        state;
    logic [31:0]   fifo [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [31:0]   head_addr;
    logic [31:0]   fetch_addr;
    logic          hit;
    logic          miss;
    logic          push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        hit        = instr_req && (count != '0) && (instr_addr == head_addr);
        miss       = instr_req && (instr_addr != head_addr);
        push       = (state == FETCH) && mem_ack && !miss;
        count_next = count + CW'(push) - CW'(hit);
    end

    assign instr_ack  = hit;
    assign instr_data = (count != '0) ? fifo[rd_ptr] : '0;
    assign mem_req    = (state == FETCH) || (state == DROP);
    assign redirect   = miss && rstz;

    always_ff @(posedge clk) begin
        if (!rstz) begin
            state      <= IDLE;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            head_addr  <= BOOT_ADDR;
            fetch_addr <= BOOT_ADDR;
            mem_addr   <= BOOT_ADDR;
        end else if (miss) begin
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            head_addr  <= instr_addr;
            fetch_addr <= instr_addr;
            // A stale request still in flight keeps its address on the bus until acked;
            // otherwise the new target is issued on the very next cycle.
            if ((state != IDLE) && !mem_ack) begin
                state <= DROP;
            end else begin
                state    <= FETCH;
                mem_addr <= instr_addr;
            end
        end else begin
            count <= count_next;
            if (hit) begin
                rd_ptr    <= ptr_inc(rd_ptr);
                head_addr <= head_addr + 32'd4;
            end
            if (push) begin
                fifo[wr_ptr] <= mem_rdata;
                wr_ptr       <= ptr_inc(wr_ptr);
            end
            unique case (state)
                IDLE: begin
                    if (count_next < FULL) state <= FETCH;
                end
                FETCH: begin
                    if (mem_ack) begin
                        fetch_addr <= fetch_addr + 32'd4;
                        mem_addr   <= fetch_addr + 32'd4;
                        if (count_next == FULL) state <= IDLE;
                    end
                end
                DROP: begin
                    if (mem_ack) begin
                        mem_addr <= fetch_addr;
                        state    <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_kronos_instr_prefetch.sv
// Randomised and directed bench for kronos_instr_prefetch: a core driver issues fetches and
// queues the expected words; a monitor pops and compares on every instr_ack.
module tb_kronos_instr_prefetch;
    localparam logic [31:0] BOOT    = 32'h0;
    localparam int          TIMEOUT = 200;

    logic        clk = 1'b0;
    logic        rstz;
    logic [31:0] instr_addr;
    logic        instr_req;
    logic [31:0] instr_data;
    logic        instr_ack;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        redirect;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   errors      = 0;
    int   checks      = 0;
    int   redirect_cnt = 0;
    int   lat         = 0;
    bit   rand_mode   = 1'b0;

    always #5 clk = ~clk;

    kronos_instr_prefetch #(
        .DEPTH(2),
        .BOOT_ADDR(BOOT)
    ) dut (
        .clk(clk),
        .rstz(rstz),
        .instr_addr(instr_addr),
        .instr_req(instr_req),
        .instr_data(instr_data),
        .instr_ack(instr_ack),
        .mem_addr(mem_addr),
        .mem_req(mem_req),
        .mem_rdata(mem_rdata),
        .mem_ack(mem_ack),
        .redirect(redirect)
    );

    // Memory contents: an injective function of the address, so any wrong word is visible.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: answers after `lat` wait states, or randomly in rand_mode.
    initial begin
        int waited;
        waited    = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (rand_mode) mem_ack = ($urandom_range(0, 1) == 1);
                else           mem_ack = (waited >= lat);
                if (mem_ack) begin
                    waited    = 0;
                    mem_rdata = mem_word(mem_addr);
                end else begin
                    waited++;
                    mem_rdata = $urandom();
                end
            end else begin
                waited    = 0;
                mem_ack   = 1'b0;
                mem_rdata = $urandom();
            end
        end
    end

    // Monitor: every served fetch must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rstz) begin
                if (redirect) redirect_cnt++;
                if (instr_ack) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ack: addr %h data %h with nothing expected", instr_addr, instr_data);
                    end else begin
                        e = sb_q.pop_front();
                        chk($sformatf("instr_data@%h", e.addr), instr_data, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rstz      = 1'b0;
        instr_req = 1'b0;
        instr_addr = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_addr", mem_addr, BOOT);
        chk("rst_instr_ack", 32'(instr_ack), 0);
        chk("rst_instr_data", instr_data, 0);
        chk("rst_redirect", 32'(redirect), 0);
        @(negedge clk);
        rstz = 1'b1;
    endtask

    task automatic issue(input logic [31:0] a);
        exp_t e;
        e.addr = a;
        e.data = mem_word(a);
        sb_q.push_back(e);
        instr_req  = 1'b1;
        instr_addr = a;
    endtask

    // Called at negedge+1; returns at the negedge after the ack with inputs untouched.
    task automatic wait_ack(output int taken);
        taken = 0;
        while (!instr_ack && taken < TIMEOUT) begin
            @(negedge clk);
            #1;
            taken++;
        end
        if (!instr_ack) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: addr %h got no instr_ack after %0d cycles", instr_addr, taken);
            if (sb_q.size() > 0) void'(sb_q.pop_back());
            instr_req = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic fetch(input logic [31:0] a, output int taken);
        issue(a);
        #1;
        wait_ack(taken);
    endtask

    task automatic wait_mem_addr(input logic [31:0] a);
        int k;
        k = 0;
        #1;
        while (!(mem_req && mem_addr == a) && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (k >= 50) begin
            checks++;
            errors++;
            $display("FAIL mem_addr_wait: got %h expected %h", mem_addr, a);
        end
    endtask

    initial begin
        int          t;
        int          stalls;
        int          acks;
        int          rd0;
        int          branches;
        logic [31:0] a;
        bit          is_branch;

        rstz       = 1'b0;
        instr_req  = 1'b0;
        instr_addr = '0;

        // Sequential stream, zero-wait memory
        lat = 0;
        do_reset();
        issue(32'h0);
        #1;
        chk("mem_req_release", 32'(mem_req), 0);
        @(negedge clk);
        #1;
        chk("mem_req_rise", 32'(mem_req), 1);
        chk("mem_addr_first", mem_addr, BOOT);
        wait_ack(t);
        chk("first_ack_latency", t + 1, 2);
        rd0    = redirect_cnt;
        stalls = 0;
        for (int i = 1; i < 12; i++) begin
            fetch(32'(i * 4), t);
            if (t != 0) stalls++;
        end
        chk("stream_stalls", stalls, 0);
        chk("stream_redirects", redirect_cnt - rd0, 0);

        // Branch after 0x8; miss coincides with a FETCH ack
        do_reset();
        for (int i = 0; i < 3; i++) fetch(32'(i * 4), t);
        rd0 = redirect_cnt;
        issue(32'h800);
        #1;
        chk("branch_redirect", 32'(redirect), 1);
        chk("branch_no_ack", 32'(instr_ack), 0);
        @(negedge clk);
        #1;
        chk("branch_redirect_off", 32'(redirect), 0);
        chk("branch_mem_addr", mem_addr, 32'h800);
        chk("branch_mem_req", 32'(mem_req), 1);
        wait_ack(t);
        chk("branch_latency", t + 1, 2);
        fetch(32'h804, t);
        chk("branch_seq1", t, 0);
        fetch(32'h808, t);
        chk("branch_seq2", t, 0);
        chk("branch_redirects", redirect_cnt - rd0, 1);

        // Full FIFO: core idle for 10 cycles
        do_reset();
        acks = 0;
        repeat (10) begin
            #1;
            if (mem_req && mem_ack) acks++;
            @(negedge clk);
        end
        chk("full_mem_acks", acks, 2);
        #1;
        chk("full_mem_req_off", 32'(mem_req), 0);
        @(negedge clk);
        stalls = 0;
        for (int i = 0; i < 6; i++) begin
            fetch(32'(i * 4), t);
            if (t != 0) stalls++;
        end
        chk("full_resume_stalls", stalls, 0);

        // Stale drop: 0x8 outstanding with 2 wait states, redirect to 0x100
        lat = 2;
        do_reset();
        fetch(32'h0, t);
        chk("slow_first_latency", t, 4);
        instr_req = 1'b0;
        wait_mem_addr(32'h8);
        @(negedge clk);
        issue(32'h100);
        #1;
        chk("drop_redirect", 32'(redirect), 1);
        chk("drop_hold_addr0", mem_addr, 32'h8);
        @(negedge clk);
        #1;
        chk("drop_hold_addr1", mem_addr, 32'h8);
        chk("drop_mem_req", 32'(mem_req), 1);
        chk("drop_redirect_off", 32'(redirect), 0);
        @(negedge clk);
        #1;
        chk("drop_new_addr", mem_addr, 32'h100);
        chk("drop_new_req", 32'(mem_req), 1);
        wait_ack(t);
        chk("drop_latency", t, 3);

        // Miss in the same cycle as the FETCH ack of 0x8: no DROP
        do_reset();
        fetch(32'h0, t);
        instr_req = 1'b0;
        wait_mem_addr(32'h8);
        @(negedge clk);
        @(negedge clk);
        issue(32'h200);
        #1;
        chk("simul_redirect", 32'(redirect), 1);
        @(negedge clk);
        #1;
        chk("simul_mem_addr", mem_addr, 32'h200);
        chk("simul_mem_req", 32'(mem_req), 1);
        wait_ack(t);
        chk("simul_latency", t, 3);

        // Reset while a request is outstanding and the FIFO holds a word
        do_reset();
        repeat (5) @(negedge clk);
        rstz       = 1'b0;
        instr_req  = 1'b1;
        instr_addr = 32'h0;
        #1;
        chk("midrst_req_before", 32'(mem_req), 1);
        @(negedge clk);
        #1;
        chk("midrst_mem_req", 32'(mem_req), 0);
        chk("midrst_mem_addr", mem_addr, BOOT);
        chk("midrst_instr_ack", 32'(instr_ack), 0);
        chk("midrst_instr_data", instr_data, 0);
        chk("midrst_redirect", 32'(redirect), 0);
        @(negedge clk);
        do_reset();
        fetch(BOOT, t);
        chk("midrst_restart_latency", t, 4);

        // Address wrap at the top of memory
        lat = 0;
        do_reset();
        fetch(32'h0, t);
        fetch(32'hFFFF_FFF8, t);
        chk("wrap_branch_latency", t, 2);
        stalls = 0;
        fetch(32'hFFFF_FFFC, t);
        if (t != 0) stalls++;
        fetch(32'h0, t);
        if (t != 0) stalls++;
        fetch(32'h4, t);
        if (t != 0) stalls++;
        chk("wrap_stalls", stalls, 0);

        // Random: random memory acks, idle gaps and branches
        do_reset();
        rand_mode = 1'b1;
        rd0       = redirect_cnt;
        branches  = 0;
        a         = BOOT;
        is_branch = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (is_branch) branches++;
            fetch(a, t);
            case ($urandom_range(0, 9))
                0, 1: begin
                    a = ($urandom() & 32'hFFFF_FFFC);
                    is_branch = 1'b1;
                end
                2: begin
                    a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
                    is_branch = 1'b1;
                end
                default: begin
                    a = a + 32'd4;
                    is_branch = 1'b0;
                end
            endcase
            // head is now the word after the one just served; equal target is not a branch
            if (is_branch && a == instr_addr + 32'd4) a = a + 32'd8;
            if ($urandom_range(0, 3) == 0) begin
                instr_req = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
            end
        end
        chk("rand_redirects", redirect_cnt - rd0, branches);
        instr_req = 1'b0;
        rand_mode = 1'b0;
        @(negedge clk);
        #3;
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
